// File: rtl/store_buffer.sv
// Write-combining store queue in front of a single-port data memory; a store accepted at edge N can drain in cycle N+1.
// Backpressure: st_ready drops when full (no same-cycle bypass); loads are stalled while a matching word is pending or incoming.
module store_buffer #(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     st_valid,
    input  logic [31:0]              st_addr,
    input  logic [31:0]              st_wdata,
    input  logic [3:0]               st_be,
    input  logic [31:0]              st_pc,
    output logic                     st_ready,
    input  logic                     ld_valid,
    input  logic [31:0]              ld_addr,
    output logic                     ld_stall,
    output logic [31:0]              ld_data,
    output logic [31:0]              dm_addr,
    output logic [31:0]              dm_wd,
    output logic                     dm_we,
    output logic [31:0]              dm_pc,
    input  logic [31:0]              dm_rdata,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     empty
);
    localparam int AW = $clog2(DEPTH);

    logic [29:0]      r_addr  [DEPTH];
    logic [31:0]      r_wdata [DEPTH];
    logic [3:0]       r_be    [DEPTH];
    logic [31:0]      r_pc    [DEPTH];
    logic [DEPTH-1:0] r_vld;
    logic [AW-1:0]    r_head;
    logic [AW-1:0]    r_tail;
    logic [AW:0]      r_count;

    logic             w_push;
    logic             w_pop;
    logic             w_drain;
    logic             w_load_mode;
    logic             w_match_in;
    logic [DEPTH-1:0] w_hit;
    logic [31:0]      w_mask;
    logic             w_unused;

    assign w_unused = ^{st_addr[1:0], ld_addr[1:0]};

    assign count    = r_count;
    assign empty    = (r_count == '0);
    assign st_ready = (r_count != (AW+1)'(DEPTH));
    assign w_push   = st_valid && st_ready && (st_be != 4'h0);

    // Per-entry valid bits make occupancy a direct lookup instead of pointer arithmetic.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            w_hit[i] = r_vld[i] && (r_addr[i] == ld_addr[31:2]);
        end
    end

    assign w_match_in  = w_push && (st_addr[31:2] == ld_addr[31:2]);
    assign ld_stall    = ld_valid && ((|w_hit) || w_match_in);
    assign w_load_mode = ld_valid && !ld_stall;
    assign w_drain     = !w_load_mode && !empty;
    assign w_pop       = w_drain && reset;

    always_comb begin
        w_mask = '0;
        for (int i = 0; i < 4; i++) begin
            w_mask[8*i +: 8] = r_be[r_head][i] ? 8'h00 : 8'hFF;
        end
    end

    assign dm_we   = w_pop;
    assign dm_addr = w_drain ? {r_addr[r_head], 2'b00} : ld_addr;
    assign dm_pc   = w_drain ? r_pc[r_head] : 32'h0;
    assign dm_wd   = (dm_rdata & w_mask) | (r_wdata[r_head] & ~w_mask);
    assign ld_data = dm_rdata;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
            r_vld   <= '0;
        end else begin
            // Push and pop never target the same slot: push needs not-full, pop needs not-empty.
            if (w_pop) begin
                r_head        <= r_head + 1'b1;
                r_vld[r_head] <= 1'b0;
            end
            if (w_push) begin
                r_tail        <= r_tail + 1'b1;
                r_vld[r_tail] <= 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_addr[r_tail]  <= st_addr[31:2];
            r_wdata[r_tail] <= st_wdata;
            r_be[r_tail]    <= st_be;
            r_pc[r_tail]    <= st_pc;
        end
    end
endmodule

// File: doc/store_buffer.md
# store_buffer

Write-combining store queue in the MEM stage, directly upstream of the data memory. It accepts byte-enabled stores from the pipeline and queues them in a small FIFO. It drains one store per cycle into the single-port data memory whenever no load owns the port, using read-modify-write for partial stores. Loads pass straight through to the memory, and the block stalls any load whose word address matches a pending store.

## Interface
- DEPTH, 4, number of queue entries (power of two, ≥2)
- clk  in  1  system clock, all state updates on posedge
- reset  in  1  synchronous, active-low; clears queue when sampled 0 at posedge
- st_valid  in  1  store request this cycle
- st_addr  in  32  store byte address; bits [1:0] ignored (word granularity)
- st_wdata  in  32  store data, already lane-aligned
- st_be  in  4  byte enables, bit i selects byte lane [8i+7:8i]
- st_pc  in  32  PC of the store instruction, carried for the memory trace
- st_ready  out  1  queue can accept a store this cycle
- ld_valid  in  1  load request this cycle
- ld_addr  in  32  load byte address
- ld_stall  out  1  load must be held: word address matches a pending or incoming store
- ld_data  out  32  load data, equals dm_rdata
- dm_addr  out  32  memory address
- dm_wd  out  32  memory write data, merged full word
- dm_we  out  1  memory write enable
- dm_pc  out  32  PC forwarded to memory for the write trace
- dm_rdata  in  32  memory combinational read data at dm_addr
- count  out  $clog2(DEPTH)+1  occupied entries
- empty  out  1  count == 0

## Operation
- Entry fields: word address addr[31:2], wdata, be, pc. Storage is a circular FIFO with head and tail pointers that wrap modulo DEPTH.
- Enqueue:
  - A store is accepted when st_valid && st_ready && st_be != 0.
  - A store with st_be == 0 is dropped. It creates no entry and no write.
  - st_ready = (count != DEPTH). It is combinational and gives no full-bypass, so a full queue refuses the store even when a drain occurs in the same cycle.
- Port arbitration, one memory port:
  - Load mode: ld_valid && !ld_stall. In this mode dm_addr = ld_addr, dm_we = 0, and no drain occurs.
  - Drain mode: every other case with empty == 0. In this mode dm_addr = {head.addr, 2'b00}, dm_pc = head.pc, dm_we = 1, and the head entry is popped at the posedge.
  - Idle: dm_we = 0, dm_addr = ld_addr, dm_pc = 0.
- Merge: dm_wd = (dm_rdata & M) | (head.wdata & ~M), where M is the per-lane mask, 0xFF where be bit is 0. With be = 4'hF the merge reduces to head.wdata.
- Hazard check:
  - ld_stall = ld_valid && match.
  - match is true if any occupied entry has addr == ld_addr[31:2], or if a store being accepted this cycle has the same word address.
  - While stalled, the port drains. This guarantees forward progress, and the stall clears once the last matching entry retires.
- Simultaneous push and pop leave count unchanged. The pushed entry is written at tail and the popped entry is taken from head. Ordering is strictly FIFO.
- ld_data = dm_rdata at all times. Its value is meaningful only in load mode.
- Reset:
  - head = tail = count = 0.
  - All pending stores are discarded without writing.
  - Entry data contents need not be cleared.

## Timing
- All outputs are combinational from registered state and current inputs. No output is registered.
- Reset values, given ld_valid = st_valid = 0: count = 0, empty = 1, st_ready = 1, ld_stall = 0, dm_we = 0.
- Store latency: the earliest memory write is at the posedge one cycle after the acceptance edge. An entry accepted at edge N is visible as head and can drain during cycle N+1, provided it is at head and no load owns the port.
- Drain throughput is one entry per cycle. With a continuous non-stalled load stream the queue does not drain (starvation is permitted); the pipeline guarantees load-free cycles.
- A load in load mode completes combinationally in the same cycle it is presented.
- Reset asserted mid-drain suppresses the write at that edge: dm_we is forced to 0 when reset == 0.

## Test plan
- Reset: hold reset = 0 for 2 cycles with st_valid = 1 -> count = 0, empty = 1, dm_we = 0 throughout, st_ready = 1 after release.
- Full-word store: sw at 0x0000_0010, data 0xDEADBEEF, be = F, no loads -> the next cycle shows dm_we = 1, dm_addr = 0x10, dm_wd = 0xDEADBEEF, dm_pc = st_pc; count returns to 0 afterwards.
- Byte merge: store be = 4'b0010, data 0x0000AB00 at 0x20, with dm_rdata = 0x11223344 -> dm_wd = 0x1122AB44.
- Full queue: hold ld_valid = 1 at non-matching 0x100 while pushing 5 stores -> st_ready = 0 after the 4th store, the 5th store is refused, count = 4. Drop ld_valid -> four drains in order over 4 cycles.
- Hazard: pending store at 0x10 plus a load to 0x13 -> ld_stall = 1 and dm_we = 1 for 0x10. ld_stall = 0 in the cycle after the drain, and the load then sees dm_addr = 0x13.
- Reset mid-operation: 3 entries queued and ld_valid = 1 blocking the drain, then reset pulsed -> no dm_we ever asserted, count = 0 after the edge.
